// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: next-PC selection and
// return-address-stack operation codes.
package pc_pkg;

   // Winner of the redirect priority encoder, one per possible pc source.
   typedef enum logic [2:0] {
      PC_INCR,
      PC_JUMP,
      PC_RET,
      PC_TRAP,
      PC_TRAP_RET
   } pc_sel_t;

   // Operation applied to the return-address stack on an enabled cycle.
   typedef enum logic [1:0] {
      RAS_NONE,
      RAS_PUSH,
      RAS_POP,
      RAS_REPLACE
   } ras_op_t;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack. A push onto a full stack silently
// overwrites the oldest entry, saturates the count and sets a sticky
// overflow flag. The top entry reads as zero while the stack is empty.
module return_stack
   import pc_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  ras_op_t                    op,
   input  logic [XLEN-1:0]            push_data,
   output logic [XLEN-1:0]            top,
   output logic [$clog2(RAS_DEPTH):0] count,
   output logic                       overflow
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] entries [RAS_DEPTH];
   logic [PW-1:0]   top_ptr;
   logic [PW-1:0]   ptr_up;
   logic [PW-1:0]   ptr_dn;
   logic            empty;
   logic            full;

   // Pointer arithmetic wraps for free because the depth is a power of two.
   assign ptr_up = top_ptr + PW'(1);
   assign ptr_dn = top_ptr - PW'(1);
   assign empty  = (count == '0);
   assign full   = (count == CW'(RAS_DEPTH));
   assign top    = empty ? '0 : entries[top_ptr];

   // Stack storage, pointer, saturating count and sticky overflow.
   always_ff @(posedge clk) begin
      // NOTE: the entries are cleared on reset so ras_top and any later
      // replay of stale slots start from a known zero state, not X.
      if (reset) begin
         for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
         top_ptr  <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         case (op)
            RAS_PUSH: begin
               entries[ptr_up] <= push_data;
               top_ptr         <= ptr_up;
               if (full) overflow <= 1'b1;
               else      count    <= count + CW'(1);
            end
            RAS_POP: begin
               if (!empty) begin
                  top_ptr <= ptr_dn;
                  count   <= count - CW'(1);
               end
            end
            RAS_REPLACE: begin
               if (!empty) entries[top_ptr] <= push_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: priority-encodes the redirect
// requests, selects the next pc, and keeps the EPC register and the
// return-address stack in step with it.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              STEP         = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0010),
   parameter int              RAS_DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pc_enable,
   input  logic                       jump_en,
   input  logic [XLEN-1:0]            jump_to,
   input  logic                       call_en,
   input  logic                       ret_en,
   input  logic                       trap_en,
   input  logic                       trap_ret_en,
   output logic [XLEN-1:0]            pc,
   output logic [XLEN-1:0]            link_value,
   output logic [XLEN-1:0]            epc,
   output logic [XLEN-1:0]            ras_top,
   output logic [$clog2(RAS_DEPTH):0] ras_count,
   output logic                       ras_overflow
);

   pc_sel_t         sel;
   ras_op_t         ras_op;
   logic [XLEN-1:0] pc_next;
   logic            ras_empty;

   // Sequential address; wraps modulo 2^XLEN without comment.
   assign link_value = pc + XLEN'(STEP);
   assign ras_empty  = (ras_count == '0);

   // Redirect priority: trap > trap return > return > jump > increment.
   always_comb begin
      // NOTE: default assigned first so every path drives sel (no latch).
      sel = PC_INCR;
      if (trap_en)          sel = PC_TRAP;
      else if (trap_ret_en) sel = PC_TRAP_RET;
      else if (ret_en)      sel = PC_RET;
      else if (jump_en)     sel = PC_JUMP;
   end

   // Next-pc mux and the matching stack operation. A return on an empty
   // stack falls back to jump_to, and with call_en it becomes a plain push.
   always_comb begin
      pc_next = link_value;
      ras_op  = RAS_NONE;
      case (sel)
         PC_JUMP: begin
            pc_next = jump_to;
            if (call_en) ras_op = RAS_PUSH;
         end
         PC_RET: begin
            if (ras_empty) begin
               pc_next = jump_to;
               if (call_en) ras_op = RAS_PUSH;
            end else begin
               pc_next = ras_top;
               ras_op  = call_en ? RAS_REPLACE : RAS_POP;
            end
         end
         PC_TRAP:     pc_next = TRAP_VECTOR;
         PC_TRAP_RET: pc_next = epc;
         default:     pc_next = link_value;
      endcase
      if (!pc_enable) ras_op = RAS_NONE;
   end

   // pc and epc registers; epc captures the faulting pc on trap entry.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so epc takes the pre-edge pc, not the new one.
      if (reset) begin
         pc  <= RESET_VECTOR;
         epc <= '0;
      end else if (pc_enable) begin
         pc <= pc_next;
         if (sel == PC_TRAP) epc <= pc;
      end
   end

   return_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .op        (ras_op),
      .push_data (link_value),
      .top       (ras_top),
      .count     (ras_count),
      .overflow  (ras_overflow)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0;
   localparam logic [31:0] TV = 32'h10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_enable = 1'b0;
   logic        jump_en = 1'b0;
   logic [31:0] jump_to = '0;
   logic        call_en = 1'b0;
   logic        ret_en = 1'b0;
   logic        trap_en = 1'b0;
   logic        trap_ret_en = 1'b0;
   logic [31:0] pc;
   logic [31:0] link_value;
   logic [31:0] epc;
   logic [31:0] ras_top;
   logic [2:0]  ras_count;
   logic        ras_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic        m_ovf;
   logic [31:0] m_ras[$];

   pc_sequencer #(
      .XLEN         (32),
      .STEP         (4),
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV),
      .RAS_DEPTH    (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_enable    (pc_enable),
      .jump_en      (jump_en),
      .jump_to      (jump_to),
      .call_en      (call_en),
      .ret_en       (ret_en),
      .trap_en      (trap_en),
      .trap_ret_en  (trap_ret_en),
      .pc           (pc),
      .link_value   (link_value),
      .epc          (epc),
      .ras_top      (ras_top),
      .ras_count    (ras_count),
      .ras_overflow (ras_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_top();
      return (m_ras.size() > 0) ? m_ras[$] : 32'h0;
   endfunction

   task automatic m_push(input logic [31:0] v);
      if (m_ras.size() == 4) begin
         void'(m_ras.pop_front());
         m_ovf = 1'b1;
      end
      m_ras.push_back(v);
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_update();
      logic [31:0] link;
      link = m_pc + 32'd4;
      if (reset) begin
         m_pc  = RV;
         m_epc = '0;
         m_ovf = 1'b0;
         m_ras.delete();
      end else if (pc_enable) begin
         if (trap_en) begin
            m_epc = m_pc;
            m_pc  = TV;
         end else if (trap_ret_en) begin
            m_pc = m_epc;
         end else if (ret_en) begin
            if (m_ras.size() > 0) begin
               m_pc = m_ras[$];
               if (call_en) m_ras[m_ras.size()-1] = link;
               else         void'(m_ras.pop_back());
            end else begin
               m_pc = jump_to;
               if (call_en) m_push(link);
            end
         end else if (jump_en) begin
            if (call_en) m_push(link);
            m_pc = jump_to;
         end else begin
            m_pc = link;
         end
      end
   endtask

   task automatic compare_all();
      check("pc", pc, m_pc);
      check("link_value", link_value, m_pc + 32'd4);
      check("epc", epc, m_epc);
      check("ras_top", ras_top, m_top());
      check("ras_count", {29'd0, ras_count}, m_ras.size());
      check("ras_overflow", {31'd0, ras_overflow}, {31'd0, m_ovf});
   endtask

   // Drive one cycle of inputs, clock it, update the model, compare after the edge.
   task automatic step(input logic r, input logic en, input logic j, input logic c,
                       input logic rt, input logic t, input logic tr, input logic [31:0] jt);
      reset       = r;
      pc_enable   = en;
      jump_en     = j;
      call_en     = c;
      ret_en      = rt;
      trap_en     = t;
      trap_ret_en = tr;
      jump_to     = jt;
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(0, 1, 0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic jump(input logic [31:0] t, input logic c);
      step(0, 1, 1, c, 0, 0, 0, t);
   endtask

   task automatic ret(input logic [31:0] t);
      step(0, 1, 0, 0, 1, 0, 0, t);
   endtask

   logic [31:0] exp_ret [4];

   initial begin
      m_pc  = RV;
      m_epc = '0;
      m_ovf = 1'b0;

      // Reset, then sequential increments.
      step(1, 0, 0, 0, 0, 0, 0, 32'h0);
      step(1, 1, 1, 1, 0, 0, 0, 32'h1234);
      check("reset_pc", pc, RV);
      check("reset_count", {29'd0, ras_count}, 32'd0);
      idle(); idle(); idle();
      check("incr_pc_12", pc, 32'd12);
      check("incr_link_16", link_value, 32'd16);

      // Call then return.
      jump(32'h100, 0);
      jump(32'h200, 1);
      check("call_pc", pc, 32'h200);
      check("call_top", ras_top, 32'h104);
      check("call_count", {29'd0, ras_count}, 32'd1);
      ret(32'h0);
      check("ret_pc", pc, 32'h104);
      check("ret_count", {29'd0, ras_count}, 32'd0);

      // Five nested calls into a four-deep stack.
      for (int i = 0; i < 5; i++) jump(32'h1000 + 32'(i) * 32'h100, 1);
      check("ovf_count", {29'd0, ras_count}, 32'd4);
      check("ovf_flag", {31'd0, ras_overflow}, 32'd1);
      exp_ret[0] = 32'h1304; exp_ret[1] = 32'h1204;
      exp_ret[2] = 32'h1104; exp_ret[3] = 32'h1004;
      for (int i = 0; i < 4; i++) begin
         ret(32'h0);
         check("lifo_ret", pc, exp_ret[i]);
      end
      ret(32'h500);
      check("empty_ret_pc", pc, 32'h500);
      check("empty_ret_count", {29'd0, ras_count}, 32'd0);

      // Trap beats jump and call; trap return restores pc.
      jump(32'h40, 1);
      step(0, 1, 1, 1, 0, 1, 0, 32'h999);
      check("trap_pc", pc, TV);
      check("trap_epc", epc, 32'h40);
      check("trap_ras_top", ras_top, 32'h504);
      check("trap_ras_count", {29'd0, ras_count}, 32'd1);
      step(0, 1, 0, 0, 0, 0, 1, 32'h0);
      check("trap_ret_pc", pc, 32'h40);

      // Return with call on a non-empty stack replaces the top.
      step(0, 1, 0, 1, 1, 0, 0, 32'h0);
      check("replace_pc", pc, 32'h504);
      check("replace_top", ras_top, 32'h44);
      check("replace_count", {29'd0, ras_count}, 32'd1);

      // Address wrap and enable hold.
      jump(32'hFFFF_FFFC, 0);
      idle();
      check("wrap_pc", pc, 32'h0);
      step(0, 0, 1, 1, 0, 0, 0, 32'h300);
      step(0, 0, 0, 0, 0, 1, 0, 32'h300);
      check("hold_pc", pc, 32'h0);

      // Reset with a pending jump while the stack is full.
      for (int i = 0; i < 4; i++) jump(32'h2000 + 32'(i) * 32'h10, 1);
      step(1, 1, 1, 0, 0, 0, 0, 32'h700);
      check("rst_full_pc", pc, RV);
      check("rst_full_count", {29'd0, ras_count}, 32'd0);
      check("rst_full_ovf", {31'd0, ras_overflow}, 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] jt;
         jt = ($urandom_range(0, 3) == 0) ? $urandom() : {20'd0, 10'($urandom()), 2'b00};
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 11) == 0),
              jt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
